// File: rtl/dot_product_relu.sv
// dot_product_relu: Avalon-MM neuron accelerator.
// Computes y = act(bias + sum w[i]*x[i]) in signed fixed point. Weight and
// activation vectors are fetched from SDRAM through the master port. The
// result word is written back through the master port, and the CPU can
// also read it from slave offset 0.
//
// Slave handshake: a CPU access completes on a rising edge where
// slave_waitrequest is low. Master handshake: a request (read or write)
// completes on a rising edge where master_waitrequest is low, and read data
// arrives later on any edge with master_readdatavalid high. At most one
// read is outstanding at a time.
module dot_product_relu #(
    parameter int FRAC_BITS  = 16,
    parameter int WORD_BYTES = 4
) (
    input  logic        clk,
    input  logic        rst,
    // CPU configuration/status port
    output logic        slave_waitrequest,
    input  logic [3:0]  slave_address,
    input  logic        slave_read,
    output logic [31:0] slave_readdata,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    // SDRAM master port
    input  logic        master_waitrequest,
    output logic [31:0] master_address,
    output logic        master_read,
    input  logic [31:0] master_readdata,
    input  logic        master_readdatavalid,
    output logic        master_write,
    output logic [31:0] master_writedata
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_W   = 3'd1,
        S_WAIT_W = 3'd2,
        S_RD_A   = 3'd3,
        S_WAIT_A = 3'd4,
        S_MAC    = 3'd5,
        S_WR_OUT = 3'd6
    } state_t;

    state_t state_q, state_d;

    // Configuration registers, writable from the CPU only while idle.
    logic [31:0] wbase_q;
    logic [31:0] abase_q;
    logic [31:0] bias_q;
    logic [31:0] len_q;
    logic [31:0] outaddr_q;
    logic        relu_en_q;

    // Run-time datapath registers.
    logic [31:0] acc_q, acc_d;
    logic [31:0] idx_q, idx_d;
    logic [31:0] w_q, w_d;
    logic [31:0] x_q, x_d;
    logic [31:0] result_q, result_d;
    logic [31:0] readdata_q;

    // Decoded helpers.
    logic               is_idle;
    logic               cfg_wr;
    logic               start;
    logic [31:0]        elem_off;
    logic [31:0]        idx_next;
    logic signed [63:0] prod;
    logic [31:0]        prod_scaled;
    logic [31:0]        relu_val;
    logic               unused_prod_bits;

    assign is_idle  = (state_q == S_IDLE);
    assign cfg_wr   = is_idle && slave_write;
    assign start    = cfg_wr && (slave_address == 4'd0);
    assign elem_off = idx_q * 32'(WORD_BYTES);
    assign idx_next = idx_q + 32'd1;

    // Full-precision signed product; the Q-format result keeps the 32 bits
    // just above the fractional LSBs, wrapping silently on overflow.
    assign prod             = $signed(w_q) * $signed(x_q);
    assign prod_scaled      = prod[FRAC_BITS+31:FRAC_BITS];
    assign unused_prod_bits = ^{prod[63:FRAC_BITS+32], prod[FRAC_BITS-1:0]};

    // Optional ReLU: negative accumulator values are clamped to zero.
    assign relu_val = (relu_en_q && acc_q[31]) ? 32'd0 : acc_q;

    // The CPU is stalled for the whole duration of a run.
    assign slave_waitrequest = !is_idle;
    assign slave_readdata    = readdata_q;

    // FSM state register and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= 32'd0;
            idx_q    <= 32'd0;
            w_q      <= 32'd0;
            x_q      <= 32'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            w_q      <= w_d;
            x_q      <= x_d;
            result_q <= result_d;
        end
    end

    // Configuration register writes (offsets 1..6); offset 0 is the start strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbase_q   <= 32'd0;
            abase_q   <= 32'd0;
            bias_q    <= 32'd0;
            len_q     <= 32'd0;
            outaddr_q <= 32'd0;
            relu_en_q <= 1'b0;
        end else if (cfg_wr) begin
            case (slave_address)
                4'd1:    wbase_q   <= slave_writedata;
                4'd2:    abase_q   <= slave_writedata;
                4'd3:    bias_q    <= slave_writedata;
                4'd4:    len_q     <= slave_writedata;
                4'd5:    outaddr_q <= slave_writedata;
                4'd6:    relu_en_q <= slave_writedata[0];
                default: ;
            endcase
        end
    end

    // Registered CPU read data, valid the cycle after an accepted read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            readdata_q <= 32'd0;
        end else if (is_idle && slave_read) begin
            case (slave_address)
                4'd0:    readdata_q <= result_q;
                4'd1:    readdata_q <= wbase_q;
                4'd2:    readdata_q <= abase_q;
                4'd3:    readdata_q <= bias_q;
                4'd4:    readdata_q <= len_q;
                4'd5:    readdata_q <= outaddr_q;
                4'd6:    readdata_q <= {31'd0, relu_en_q};
                default: readdata_q <= 32'd0;
            endcase
        end
    end

    // Next-state logic, datapath updates and master port outputs.
    always_comb begin
        state_d          = state_q;
        acc_d            = acc_q;
        idx_d            = idx_q;
        w_d              = w_q;
        x_d              = x_q;
        result_d         = result_q;
        master_read      = 1'b0;
        master_write     = 1'b0;
        master_address   = 32'd0;
        master_writedata = 32'd0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = bias_q;
                    idx_d   = 32'd0;
                    state_d = (len_q != 32'd0) ? S_RD_W : S_WR_OUT;
                end
            end
            S_RD_W: begin
                master_read    = 1'b1;
                master_address = wbase_q + elem_off;
                if (!master_waitrequest) begin
                    state_d = S_WAIT_W;
                end
            end
            S_WAIT_W: begin
                if (master_readdatavalid) begin
                    w_d     = master_readdata;
                    state_d = S_RD_A;
                end
            end
            S_RD_A: begin
                master_read    = 1'b1;
                master_address = abase_q + elem_off;
                if (!master_waitrequest) begin
                    state_d = S_WAIT_A;
                end
            end
            S_WAIT_A: begin
                if (master_readdatavalid) begin
                    x_d     = master_readdata;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                acc_d   = acc_q + prod_scaled;
                idx_d   = idx_next;
                state_d = (idx_next < len_q) ? S_RD_W : S_WR_OUT;
            end
            S_WR_OUT: begin
                master_write     = 1'b1;
                master_address   = outaddr_q;
                master_writedata = relu_val;
                if (!master_waitrequest) begin
                    result_d = relu_val;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dot_product_relu.sv
// Testbench for dot_product_relu: an SDRAM responder with programmable
// stalls and read latency, a CPU driver, and a write monitor that checks
// every accepted output write against an expected queue.
module tb_dot_product_relu;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        slave_waitrequest;
    logic [3:0]  slave_address = 4'd0;
    logic        slave_read = 1'b0;
    logic [31:0] slave_readdata;
    logic        slave_write = 1'b0;
    logic [31:0] slave_writedata = 32'd0;
    logic        master_waitrequest;
    logic [31:0] master_address;
    logic        master_read;
    logic [31:0] master_readdata;
    logic        master_readdatavalid;
    logic        master_write;
    logic [31:0] master_writedata;

    always #5 clk = ~clk;

    dot_product_relu #(.FRAC_BITS(16), .WORD_BYTES(4)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .slave_waitrequest    (slave_waitrequest),
        .slave_address        (slave_address),
        .slave_read           (slave_read),
        .slave_readdata       (slave_readdata),
        .slave_write          (slave_write),
        .slave_writedata      (slave_writedata),
        .master_waitrequest   (master_waitrequest),
        .master_address       (master_address),
        .master_read          (master_read),
        .master_readdata      (master_readdata),
        .master_readdatavalid (master_readdatavalid),
        .master_write         (master_write),
        .master_writedata     (master_writedata)
    );

    // ---------------- scoreboard state ----------------
    logic [63:0] exp_q[$];          // {address, data} of expected output writes
    int          cmp_cnt = 0;
    int          err_cnt = 0;

    // ---------------- SDRAM model state ----------------
    logic [31:0] mem [0:255];
    int          stall_cycles = 0;
    int          rd_delay = 0;
    int          reads_seen = 0;
    int          writes_seen = 0;
    int          req_cnt = 0;
    logic [31:0] held_addr = 32'd0;
    logic [1:0]  held_kind = 2'b00;
    logic        pend = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_data = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // SDRAM responder: decides waitrequest on the falling edge, serves reads
    // after rd_delay extra cycles, stores writes.
    initial begin
        master_waitrequest   = 1'b0;
        master_readdatavalid = 1'b0;
        master_readdata      = 32'd0;
        forever begin
            @(negedge clk);
            master_readdatavalid = 1'b0;
            if (pend) begin
                if (pend_cnt == 0) begin
                    master_readdatavalid = 1'b1;
                    master_readdata      = pend_data;
                    pend                 = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
            if (req_cnt > 0) begin
                check("req_held_while_stalled", {30'd0, master_read, master_write}, {30'd0, held_kind});
                check("addr_stable_while_stalled", master_address, held_addr);
            end
            if (master_read || master_write) begin
                if (req_cnt < stall_cycles) begin
                    if (req_cnt == 0) begin
                        held_addr = master_address;
                        held_kind = {master_read, master_write};
                    end
                    master_waitrequest = 1'b1;
                    req_cnt++;
                end else begin
                    master_waitrequest = 1'b0;
                    req_cnt = 0;
                    if (master_read) begin
                        reads_seen++;
                        pend      = 1'b1;
                        pend_cnt  = rd_delay;
                        pend_data = mem[master_address[9:2]];
                    end else begin
                        writes_seen++;
                        mem[master_address[9:2]] = master_writedata;
                    end
                end
            end else begin
                master_waitrequest = 1'b0;
                req_cnt = 0;
            end
        end
    end

    // Monitor: every accepted output write is popped against the expected queue.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (master_write) begin
                check("rd_wr_exclusive", {31'd0, master_read}, 32'd0);
                if (!master_waitrequest) begin
                    if (exp_q.size() == 0) begin
                        cmp_cnt++;
                        err_cnt++;
                        $display("FAIL unexpected_write: addr %08h data %08h, no write expected",
                                 master_address, master_writedata);
                    end else begin
                        e = exp_q.pop_front();
                        check("write_addr", master_address, e[63:32]);
                        check("write_data", master_writedata, e[31:0]);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        slave_address   = a;
        slave_writedata = d;
        slave_write     = 1'b1;
        @(negedge clk);
        slave_write     = 1'b0;
    endtask

    task automatic cpu_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        slave_address = a;
        slave_read    = 1'b1;
        @(negedge clk);
        slave_read    = 1'b0;
        d             = slave_readdata;
    endtask

    task automatic load_cfg(input logic [31:0] wb, input logic [31:0] ab, input logic [31:0] bias,
                            input logic [31:0] n, input logic [31:0] oa, input logic [31:0] relu);
        cpu_write(4'd1, wb);
        cpu_write(4'd2, ab);
        cpu_write(4'd3, bias);
        cpu_write(4'd4, n);
        cpu_write(4'd5, oa);
        cpu_write(4'd6, relu);
    endtask

    // Starts a run that must write exp_data to exp_addr after exp_reads reads.
    task automatic run(input string name, input logic [31:0] exp_addr, input logic [31:0] exp_data,
                       input int exp_reads);
        int guard;
        exp_q.push_back({exp_addr, exp_data});
        reads_seen  = 0;
        writes_seen = 0;
        cpu_write(4'd0, 32'd0);
        check({name, "_busy_after_start"}, {31'd0, slave_waitrequest}, 32'd1);
        guard = 0;
        while (slave_waitrequest && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) begin
            cmp_cnt++;
            err_cnt++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, guard);
        end
        @(negedge clk);
        check({name, "_reads"}, reads_seen, exp_reads);
        check({name, "_writes"}, writes_seen, 32'd1);
        check({name, "_exp_q_drained"}, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    // Watchdog for anything the bounded waits do not cover.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] rd;
        int          guard;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        // basic vectors: w at 0x100, x at 0x200
        mem[8'h40] = 32'h0001_0000; mem[8'h41] = 32'h0002_0000; mem[8'h42] = 32'hFFFF_8000;
        mem[8'h80] = 32'h0002_0000; mem[8'h81] = 32'h0003_0000; mem[8'h82] = 32'h0004_0000;
        // relu vectors: w at 0x140, x at 0x240
        mem[8'h50] = 32'hFFFF_0000; mem[8'h90] = 32'h0005_0000;
        // wrap vectors: w at 0x180, x at 0x280
        mem[8'h60] = 32'h7FFF_0000; mem[8'hA0] = 32'h7FFF_0000;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_slave_waitrequest", {31'd0, slave_waitrequest}, 32'd0);
        check("rst_master_read", {31'd0, master_read}, 32'd0);
        check("rst_master_write", {31'd0, master_write}, 32'd0);
        check("rst_master_address", master_address, 32'd0);
        check("rst_master_writedata", master_writedata, 32'd0);
        check("rst_slave_readdata", slave_readdata, 32'd0);
        rst = 1'b0;

        // Basic run: 2 + 6 - 2 + 0.5 = 6.5
        load_cfg(32'h100, 32'h200, 32'h0000_8000, 32'd3, 32'h300, 32'd0);
        run("basic", 32'h300, 32'h0006_8000, 6);
        cpu_read(4'd0, rd); check("basic_result_read", rd, 32'h0006_8000);
        cpu_read(4'd4, rd); check("len_read", rd, 32'd3);
        cpu_read(4'd3, rd); check("bias_read", rd, 32'h0000_8000);
        cpu_read(4'd7, rd); check("unmapped_read", rd, 32'd0);

        // ReLU clamp, then same config reused with relu disabled: -1 * 5 = -5
        load_cfg(32'h140, 32'h240, 32'd0, 32'd1, 32'h304, 32'd1);
        run("relu_on", 32'h304, 32'h0000_0000, 2);
        cpu_read(4'd0, rd); check("relu_on_result_read", rd, 32'd0);
        cpu_write(4'd6, 32'd0);
        run("relu_off", 32'h304, 32'hFFFB_0000, 2);
        cpu_read(4'd6, rd); check("relu_en_read", rd, 32'd0);

        // Memory stalls: same result as the basic run
        stall_cycles = 3;
        rd_delay     = 4;
        load_cfg(32'h100, 32'h200, 32'h0000_8000, 32'd3, 32'h308, 32'd0);
        run("stall", 32'h308, 32'h0006_8000, 6);
        stall_cycles = 0;
        rd_delay     = 0;

        // Zero length: bias written straight out
        load_cfg(32'h100, 32'h200, 32'h0001_8000, 32'd0, 32'h30C, 32'd0);
        run("zero_len", 32'h30C, 32'h0001_8000, 0);

        // Wrap: 0x7FFF0000^2 = 0x3FFF0001_00000000, bits [47:16] = 0x00010000
        load_cfg(32'h180, 32'h280, 32'h0000_1000, 32'd1, 32'h310, 32'd0);
        run("wrap", 32'h310, 32'h0001_1000, 2);

        // Reset mid-operation during WAIT_A, then a late readdatavalid
        rd_delay = 6;
        load_cfg(32'h100, 32'h200, 32'h0000_8000, 32'd3, 32'h320, 32'd0);
        reads_seen = 0;
        cpu_write(4'd0, 32'd0);
        guard = 0;
        while (reads_seen < 2 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("midrst_reached_second_read", reads_seen, 32'd2);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_master_read", {31'd0, master_read}, 32'd0);
        check("midrst_master_write", {31'd0, master_write}, 32'd0);
        check("midrst_master_address", master_address, 32'd0);
        check("midrst_slave_waitrequest", {31'd0, slave_waitrequest}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("midrst_stays_idle", {31'd0, slave_waitrequest}, 32'd0);
        end
        cpu_read(4'd1, rd); check("midrst_cfg_cleared", rd, 32'd0);
        cpu_read(4'd0, rd); check("midrst_result_cleared", rd, 32'd0);
        rd_delay = 0;
        load_cfg(32'h180, 32'h280, 32'd0, 32'd1, 32'h314, 32'd0);
        run("after_rst", 32'h314, 32'h0001_0000, 2);
        cpu_read(4'd0, rd); check("after_rst_result_read", rd, 32'h0001_0000);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/dot_product_relu.md
Name: dot_product_relu

Overview:
- Avalon-MM accelerator that computes one neuron output: y = act(bias + sum over i of w[i]*x[i]), in signed Q16.16.
- Sits downstream of the word-copy engine, which stages weight and activation vectors into SDRAM. This block reads those vectors through its master port and writes the single result word back to SDRAM.
- The CPU configures and starts it through the slave port. The result is also readable from the slave port.

Parameters:
FRAC_BITS, 16, fractional bits of the fixed-point format; product is right-shifted by this amount.
WORD_BYTES, 4, address increment per vector element.

Ports:
clk  input  1  single clock; everything on the rising edge
rst  input  1  asynchronous, active-high reset
slave_waitrequest  output  1  high whenever state != IDLE
slave_address  input  4  word offset of the register
slave_read  input  1  CPU read strobe
slave_readdata  output  32  read data
slave_write  input  1  CPU write strobe
slave_writedata  input  32  write data
master_waitrequest  input  1  SDRAM stall
master_address  output  32  SDRAM byte address
master_read  output  1  read request
master_readdata  input  32  read data
master_readdatavalid  input  1  read data valid; may lag acceptance by any number of cycles
master_write  output  1  write request
master_writedata  output  32  write data

Behaviour:
- Reset (async, rst=1): state=IDLE; all config registers, accumulator, index and result cleared to 0; master_read=master_write=0; master_address=0; master_writedata=0; slave_readdata=0; slave_waitrequest=0.
- Register map (writes accepted in IDLE only):
  - 1 = weight base (byte address)
  - 2 = activation base
  - 3 = bias (Q16.16)
  - 4 = length N (unsigned)
  - 5 = output address
  - 6 = relu_en (bit 0)
  - write to 0 = start
  - Reads of 0 return the last result. Reads of 1–6 return the register value, registered, so readdata is valid the cycle after slave_read. Other offsets read 0.
- START: on a write to offset 0 in IDLE, acc <= bias and i <= 0. Go to RD_W if N != 0, otherwise go to WR_OUT.
- RD_W: master_address = wbase + i*WORD_BYTES, master_read = 1. Hold both while master_waitrequest = 1. On the cycle master_waitrequest = 0, drop master_read and go to WAIT_W.
- WAIT_W: on master_readdatavalid, latch w and go to RD_A. Only one read is outstanding at any time.
- RD_A / WAIT_A: same as RD_W / WAIT_W, using abase; latch x.
- MAC: p = signed 32x32 -> 64 product. acc <= acc + p[FRAC_BITS+31:FRAC_BITS], two's-complement wrap, no saturation. i <= i+1. Go to RD_W if i+1 < N, otherwise WR_OUT.
- WR_OUT: r = (relu_en && acc[31]) ? 0 : acc. Drive master_address = outaddr, master_writedata = r, master_write = 1 until master_waitrequest = 0. Then result <= r, drop master_write, go to IDLE.
- slave_waitrequest is high in every non-IDLE state, so the CPU stalls on any access during a run. It goes low the cycle after the output write is accepted.
- master_read and master_write are never high in the same cycle.
- master_readdatavalid outside WAIT_W/WAIT_A is ignored.
- Length and index are 32-bit unsigned. Address arithmetic wraps mod 2^32.
- Config registers persist across runs; a second start reuses them.

Test Plan:
- Basic run: w=[0x00010000, 0x00020000, 0xFFFF8000] (1, 2, -0.5), x=[0x00020000, 0x00030000, 0x00040000], bias=0x00008000, N=3, relu_en=0 -> one write to outaddr of 0x00068000 (6.5); offset-0 read returns 0x00068000; exactly 6 reads issued.
- ReLU clamp: w=[0xFFFF0000] (-1), x=[0x00050000], bias=0, N=1. relu_en=1 -> written value 0x00000000; relu_en=0 -> 0xFFFB0000.
- Memory stalls: master_waitrequest held high 3 cycles on each request and readdatavalid delayed 4 cycles after acceptance -> master_read/master_address stay stable while stalled; result identical to the basic run; slave_waitrequest high throughout.
- Zero length: N=0, bias=0x00018000 -> no reads; a single write of 0x00018000 to outaddr.
- Reset mid-operation: assert rst during WAIT_A -> master_read=master_write=0 immediately; a late readdatavalid is ignored; a new start with fresh config gives the correct result.
- Wrap: w=x=[0x7FFF0000], N=1 -> accumulator takes the truncated product bits [47:16] with no saturation: 0x00010000 plus bias.
